// File: rtl/ccr_unit.sv
// ccr_unit: condition-code register for the 8-bit pipelined core.
// Latches Z/N/C/V from write-back under per-flag enables, evaluates branch
// predicates through a write-back bypass, consumes the tested flag on a taken
// branch, and keeps a small shadow stack of CCR snapshots for nested interrupts.
module ccr_unit #(
  parameter int SHADOW_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic [3:0] flag_we,
  input  logic       br_eval,
  input  logic [2:0] br_cond,
  input  logic       int_save,
  input  logic       rti_restore,
  output logic [3:0] ccr,
  output logic       carry_out,
  output logic       br_taken,
  output logic       stack_empty,
  output logic       stack_full,
  output logic       stack_err
);

  // Stack pointer counts 0..SHADOW_DEPTH, so three bits cover depths up to 4.
  localparam logic [2:0] DEPTH_L = 3'(SHADOW_DEPTH);

  logic [3:0] ccr_r;
  logic [2:0] sp_r;
  logic       err_r;
  logic [3:0] stack_r [0:3];

  logic [3:0] alu_flags_s;
  logic [3:0] wb_ccr_s;
  logic       pred_s;
  logic       taken_s;
  logic [3:0] consume_s;
  logic [3:0] next_ccr_s;
  logic [1:0] push_idx_s;
  logic [1:0] pop_idx_s;
  logic       at_full_s;
  logic       at_empty_s;

  // Predicate select on the bypassed flags {V,C,N,Z}.
  function automatic logic eval_pred(input logic [2:0] cond, input logic [3:0] f);
    logic r;
    case (cond)
      3'b000:  r = 1'b1;
      3'b001:  r = f[0];
      3'b010:  r = f[1];
      3'b011:  r = f[2];
      3'b100:  r = f[3];
      3'b101:  r = ~f[0];
      3'b110:  r = ~f[2];
      3'b111:  r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign alu_flags_s = {alu_v, alu_c, alu_n, alu_z};
  assign wb_ccr_s    = (alu_flags_s & flag_we) | (ccr_r & ~flag_we);
  assign at_full_s   = (sp_r == DEPTH_L);
  assign at_empty_s  = (sp_r == 3'd0);
  // Entries above sp never get written, so the low two bits index safely;
  // at sp==4 the pop index wraps to entry 3 as intended.
  assign push_idx_s  = sp_r[1:0];
  assign pop_idx_s   = sp_r[1:0] - 2'd1;

  // Branch resolution and flag consumption; only direct flag tests consume.
  always_comb begin
    pred_s    = eval_pred(br_cond, wb_ccr_s);
    taken_s   = br_eval & ~stall & pred_s;
    consume_s = 4'b0000;
    if (taken_s) begin
      case (br_cond)
        3'b001:  consume_s = 4'b0001;
        3'b010:  consume_s = 4'b0010;
        3'b011:  consume_s = 4'b0100;
        3'b100:  consume_s = 4'b1000;
        default: consume_s = 4'b0000;
      endcase
    end else begin
      consume_s = 4'b0000;
    end
    next_ccr_s = wb_ccr_s & ~consume_s;
  end

  // CCR, stack pointer and sticky error; stall freezes everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_r <= 4'b0000;
      sp_r  <= 3'd0;
      err_r <= 1'b0;
    end else if (!stall) begin
      if (int_save && rti_restore) begin
        ccr_r <= next_ccr_s;
        err_r <= 1'b1;
      end else if (int_save) begin
        ccr_r <= next_ccr_s;
        if (at_full_s) begin
          err_r <= 1'b1;
        end else begin
          sp_r <= sp_r + 3'd1;
        end
      end else if (rti_restore) begin
        if (at_empty_s) begin
          err_r <= 1'b1;
        end else begin
          ccr_r <= stack_r[pop_idx_s];
          sp_r  <= sp_r - 3'd1;
        end
      end else begin
        ccr_r <= next_ccr_s;
      end
    end
  end

  // Snapshot storage; contents are don't-care after reset so no reset term.
  always_ff @(posedge clk) begin
    if (!rst && !stall && int_save && !rti_restore && !at_full_s) begin
      stack_r[push_idx_s] <= next_ccr_s;
    end
  end

  assign ccr         = ccr_r;
  assign carry_out   = ccr_r[2];
  assign br_taken    = taken_s;
  assign stack_empty = at_empty_s;
  assign stack_full  = at_full_s;
  assign stack_err   = err_r;

endmodule

// File: tb/tb_ccr_unit.sv
// Directed self-checking bench for ccr_unit (SHADOW_DEPTH=2).
module tb_ccr_unit;

  logic       clk = 1'b0;
  logic       rst, stall, alu_z, alu_n, alu_c, alu_v;
  logic [3:0] flag_we;
  logic       br_eval;
  logic [2:0] br_cond;
  logic       int_save, rti_restore;
  logic [3:0] ccr;
  logic       carry_out, br_taken, stack_empty, stack_full, stack_err;

  int n_tests = 0;
  int n_fail  = 0;

  ccr_unit #(.SHADOW_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .flag_we(flag_we), .br_eval(br_eval), .br_cond(br_cond),
    .int_save(int_save), .rti_restore(rti_restore),
    .ccr(ccr), .carry_out(carry_out), .br_taken(br_taken),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs then change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; flag_we = 4'b0000; br_eval = 1'b0; br_cond = 3'b000;
    int_save = 1'b0; rti_restore = 1'b0;
    {alu_v, alu_c, alu_n, alu_z} = 4'b0000;
  endtask

  // Write-back of {V,C,N,Z} under the given enables.
  task automatic wb(input logic [3:0] we, input logic [3:0] vcnz);
    flag_we = we;
    {alu_v, alu_c, alu_n, alu_z} = vcnz;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    // Reset state
    check("rst_ccr", {4'h0, ccr}, 8'h00);
    check("rst_carry", {7'h0, carry_out}, 8'h00);
    check("rst_empty", {7'h0, stack_empty}, 8'h01);
    check("rst_full", {7'h0, stack_full}, 8'h00);
    check("rst_err", {7'h0, stack_err}, 8'h00);
    check("rst_taken", {7'h0, br_taken}, 8'h00);

    // Full flag write: 1-cycle latency
    wb(4'b1111, 4'b0101);
    #1;
    check("wr_before", {4'h0, ccr}, 8'h00);
    tick();
    idle();
    check("wr_ccr", {4'h0, ccr}, 8'h05);
    check("wr_carry", {7'h0, carry_out}, 8'h01);

    // Bypass + consumption of Z, N write survives
    do_reset();
    wb(4'b0011, 4'b0011);
    br_eval = 1'b1; br_cond = 3'b001;
    #1;
    check("byp_taken", {7'h0, br_taken}, 8'h01);
    tick();
    idle();
    check("byp_consume", {4'h0, ccr}, 8'h02);

    // Set C, then !C (no consume) and C (consume)
    wb(4'b0100, 4'b0100);
    tick();
    idle();
    check("setc", {4'h0, ccr}, 8'h06);
    br_eval = 1'b1; br_cond = 3'b110;
    #1;
    check("notc_taken", {7'h0, br_taken}, 8'h00);
    tick();
    check("notc_ccr", {4'h0, ccr}, 8'h06);
    br_cond = 3'b011;
    #1;
    check("c_taken", {7'h0, br_taken}, 8'h01);
    tick();
    check("c_consume", {4'h0, ccr}, 8'h02);
    br_cond = 3'b101;
    #1;
    check("notz_taken", {7'h0, br_taken}, 8'h01);
    tick();
    check("notz_ccr", {4'h0, ccr}, 8'h02);
    br_cond = 3'b010;
    #1;
    check("n_taken", {7'h0, br_taken}, 8'h01);
    tick();
    check("n_consume", {4'h0, ccr}, 8'h00);
    br_cond = 3'b111;
    #1;
    check("never", {7'h0, br_taken}, 8'h00);
    br_cond = 3'b000;
    #1;
    check("always", {7'h0, br_taken}, 8'h01);
    br_cond = 3'b100;
    #1;
    check("v_clear", {7'h0, br_taken}, 8'h00);
    tick();
    idle();
    check("always_ccr", {4'h0, ccr}, 8'h00);

    // Shadow stack: push 1010, push with same-cycle write 0011, overflow
    do_reset();
    wb(4'b1111, 4'b1010);
    tick();
    idle();
    int_save = 1'b1;
    tick();
    check("push1_empty", {7'h0, stack_empty}, 8'h00);
    check("push1_full", {7'h0, stack_full}, 8'h00);
    wb(4'b1111, 4'b0011);
    tick();
    idle();
    check("push2_ccr", {4'h0, ccr}, 8'h03);
    check("push2_full", {7'h0, stack_full}, 8'h01);
    check("push2_err", {7'h0, stack_err}, 8'h00);
    int_save = 1'b1;
    wb(4'b0001, 4'b0000);
    tick();
    idle();
    check("ovf_full", {7'h0, stack_full}, 8'h01);
    check("ovf_err", {7'h0, stack_err}, 8'h01);
    check("ovf_ccr", {4'h0, ccr}, 8'h02);
    wb(4'b1111, 4'b1111);
    tick();
    idle();
    rti_restore = 1'b1;
    wb(4'b1111, 4'b0000);
    br_eval = 1'b1; br_cond = 3'b000;
    #1;
    check("pop_taken", {7'h0, br_taken}, 8'h01);
    tick();
    idle();
    check("pop1_ccr", {4'h0, ccr}, 8'h03);
    check("pop1_full", {7'h0, stack_full}, 8'h00);
    rti_restore = 1'b1;
    tick();
    idle();
    check("pop2_ccr", {4'h0, ccr}, 8'h0a);
    check("pop2_empty", {7'h0, stack_empty}, 8'h01);

    // Pop on empty holds ccr even with writes
    do_reset();
    wb(4'b1111, 4'b1100);
    tick();
    idle();
    rti_restore = 1'b1;
    wb(4'b1111, 4'b0101);
    tick();
    idle();
    check("unf_ccr", {4'h0, ccr}, 8'h0c);
    check("unf_err", {7'h0, stack_err}, 8'h01);
    check("unf_empty", {7'h0, stack_empty}, 8'h01);

    // Push and pop together: neither acts, ccr updates
    do_reset();
    int_save = 1'b1; rti_restore = 1'b1;
    wb(4'b1111, 4'b0110);
    tick();
    idle();
    check("both_ccr", {4'h0, ccr}, 8'h06);
    check("both_empty", {7'h0, stack_empty}, 8'h01);
    check("both_err", {7'h0, stack_err}, 8'h01);

    // Stall freezes state; reset during stall clears it
    do_reset();
    wb(4'b1111, 4'b0101);
    tick();
    idle();
    int_save = 1'b1;
    tick();
    int_save = 1'b1; rti_restore = 1'b1;
    tick();
    idle();
    stall = 1'b1;
    wb(4'b1111, 4'b1010);
    br_eval = 1'b1; br_cond = 3'b000;
    int_save = 1'b1;
    #1;
    check("stall_taken", {7'h0, br_taken}, 8'h00);
    tick();
    check("stall_ccr", {4'h0, ccr}, 8'h05);
    check("stall_empty", {7'h0, stack_empty}, 8'h00);
    check("stall_err", {7'h0, stack_err}, 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("rstall_ccr", {4'h0, ccr}, 8'h00);
    check("rstall_carry", {7'h0, carry_out}, 8'h00);
    check("rstall_empty", {7'h0, stack_empty}, 8'h01);
    check("rstall_err", {7'h0, stack_err}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
